pipe_ctrl: RTL and testbench
============================

// Module: pipe_ctrl
// PURPOSE
//  Central pipeline controller for the 5-stage core. Merges stage stall requests into the
//  stall[5:0] vector consumed by pc_reg/if_id/id_ex/ex_mem/mem_wb, and turns MEM-stage
//  exceptions into flush + PC redirect. Defers the redirect while an instruction fetch is
//  outstanding on the bus. Also keeps a stall-cycle counter and a stall watchdog.
// PARAMETERS
//  EXC_VECTOR     32'h0000_0020  redirect target for every non-ERET exception
//  STALL_TIMEOUT  1024           consecutive stall[0] cycles before stall_timeout sets
//  CNT_W          32             width of stall_cycles (saturating)
// PORTS
//  clk              in   1      core clock
//  rst              in   1      synchronous reset, active-high (`Rst_Enable)
//  stallreq_from_if in   1      IF bus fetch outstanding
//  stallreq_from_id in   1      load-use hazard
//  stallreq_from_ex in   1      multi-cycle madd/msub/div in EX
//  stallreq_from_mem in  1      data bus access outstanding
//  excepttype_i     in   32     MEM-stage exception type; 0 = none
//  cp0_epc_i        in   32     forwarded EPC, ERET target
//  stall            out  6      [0]pc [1]if_id [2]id_ex [3]ex_mem [4]mem_wb [5]wb; 1=`Stop
//  flush            out  1      clear all pipeline registers this cycle
//  pc_redirect      out  1      pc_reg loads new_pc this cycle
//  new_pc           out  32     redirect target, valid when pc_redirect=1
//  stall_cycles     out CNT_W   cycles with stall!=0 since reset, saturating
//  stall_timeout    out  1      sticky watchdog flag
// BEHAVIOUR
//  Reset: state=RUN, pend_pc=0, stall_cycles=0, stall_timeout=0, wd_cnt=0.
//   While rst=1, all outputs = 0.
//  Stall decode (RUN, no exception), highest priority wins:
//   mem -> 6'b011111; ex -> 6'b001111; id -> 6'b000111; if -> 6'b000111; none -> 0.
//  Vector: excepttype_i==32'h0000000e (ERET) -> cp0_epc_i. Any other nonzero value
//   (0x1 int, 0x8 syscall, 0xa ri, 0xc ov, 0xd trap) -> EXC_VECTOR.
//  FSM, 2 states; stall, flush, pc_redirect and new_pc are combinational from state+inputs:
//   RUN, excepttype_i!=0, stallreq_from_if=0:
//    flush=1, pc_redirect=1, new_pc=vector, stall=0; stay in RUN.
//   RUN, excepttype_i!=0, stallreq_from_if=1:
//    flush=1, pc_redirect=0, stall=0; pend_pc<=vector; -> WAIT_IF.
//   WAIT_IF, stallreq_from_if=1:
//    stall=6'b000111, flush=0, pc_redirect=0.
//    All other stallreqs and excepttype_i are ignored (pipeline is already empty).
//   WAIT_IF, stallreq_from_if=0:
//    flush=1 (squashes the stale fetch), pc_redirect=1, new_pc=pend_pc, stall=0; -> RUN.
//  Exception beats every stall request in the same cycle.
//  pc_reg contract: flush=1 with pc_redirect=0 means hold pc.
//  new_pc=0 whenever pc_redirect=0.
//  stall_cycles: +1 on each cycle with stall!=0. Holds at all-ones.
//  Watchdog:
//   wd_cnt +1 on each cycle with stall[0]=1; cleared on any cycle with stall[0]=0.
//   When wd_cnt reaches STALL_TIMEOUT-1 while stall[0]=1, stall_timeout<=1.
//   stall_timeout stays 1 until rst.
//  Reset mid-WAIT_IF: back to RUN, pend_pc discarded, no redirect issued.
// STRUCTURE
//  Shared define.v holds: `Stop/`NoStop, `Flush, exception codes (EXC_INT, EXC_SYSCALL,
//   EXC_RI, EXC_OV, EXC_TRAP, EXC_ERET), stall encodings (STALL_MEM, STALL_EX, STALL_ID,
//   STALL_IF), FSM state codes.
//  Sub-module pipe_stall_mon (input stall[0], stall-any; contains stall_cycles, wd_cnt,
//   stall_timeout). FSM, decode and vector mux stay in pipe_ctrl.
// TESTING
//  1 Priority: stallreq_from_id=1 and stallreq_from_ex=1 together -> stall=6'b001111;
//    drop ex -> 6'b000111.
//  2 Syscall, no fetch pending: excepttype_i=32'h8 for 1 cycle ->
//    flush=1, pc_redirect=1, new_pc=32'h20, stall=0 in that same cycle.
//  3 ERET: excepttype_i=32'he, cp0_epc_i=32'h0000_1234 -> new_pc=32'h1234, pc_redirect=1.
//  4 Deferred redirect:
//    Set stallreq_from_if=1 for 4 cycles. Raise int 0x1 in the first of them.
//    Required: cycle0 flush=1 pc_redirect=0; cycles1-3 stall=6'b000111 flush=0;
//    cycle4 (if=0) flush=1, pc_redirect=1, new_pc=32'h20; state back to RUN.
//  5 Ignored in WAIT_IF: stallreq_from_mem=1 and excepttype_i=0xc during WAIT_IF ->
//    stall stays 6'b000111, no extra flush.
//  6 Counters, STALL_TIMEOUT=8: hold stallreq_from_ex=1 for 8 cycles ->
//    stall_timeout=1 after cycle 8, stall_cycles=8; release -> flag stays 1 until rst.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared stall/flush encodings, exception codes and FSM states
package pipe_ctrl_pkg;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_WAIT_IF = 1'b1
  } state_e;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;
  localparam logic FLUSH   = 1'b1;

  localparam logic [31:0] EXC_NONE    = 32'h0000_0000;
  localparam logic [31:0] EXC_INT     = 32'h0000_0001;
  localparam logic [31:0] EXC_SYSCALL = 32'h0000_0008;
  localparam logic [31:0] EXC_RI      = 32'h0000_000a;
  localparam logic [31:0] EXC_OV      = 32'h0000_000c;
  localparam logic [31:0] EXC_TRAP    = 32'h0000_000d;
  localparam logic [31:0] EXC_ERET    = 32'h0000_000e;

  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_MEM  = 6'b011111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_IF   = 6'b000111;

  // ERET returns to the forwarded EPC; everything else goes to the common handler.
  function automatic logic [31:0] exc_target(input logic [31:0] exc,
                                             input logic [31:0] epc,
                                             input logic [31:0] vec);
    return (exc == EXC_ERET) ? epc : vec;
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// rtl/pipe_ctrl_if.sv - stage-request / control bundle between the pipeline and pipe_ctrl
interface pipe_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             stallreq_from_if;
  logic             stallreq_from_id;
  logic             stallreq_from_ex;
  logic             stallreq_from_mem;
  logic [31:0]      excepttype_i;
  logic [31:0]      cp0_epc_i;
  logic [5:0]       stall;
  logic             flush;
  logic             pc_redirect;
  logic [31:0]      new_pc;
  logic [CNT_W-1:0] stall_cycles;
  logic             stall_timeout;

  modport master (
    output stallreq_from_if, stallreq_from_id, stallreq_from_ex, stallreq_from_mem,
    output excepttype_i, cp0_epc_i,
    input  stall, flush, pc_redirect, new_pc, stall_cycles, stall_timeout
  );

  modport slave (
    input  stallreq_from_if, stallreq_from_id, stallreq_from_ex, stallreq_from_mem,
    input  excepttype_i, cp0_epc_i,
    output stall, flush, pc_redirect, new_pc, stall_cycles, stall_timeout
  );
endinterface

// File: rtl/pipe_stall_mon.sv
// rtl/pipe_stall_mon.sv - saturating stall-cycle counter and sticky pc-stall watchdog
module pipe_stall_mon #(
  parameter int STALL_TIMEOUT = 1024,
  parameter int CNT_W         = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_stall_pc,
  input  logic             i_stall_any,
  output logic [CNT_W-1:0] o_stall_cycles,
  output logic             o_stall_timeout
);

  localparam int              WD_W    = $clog2(STALL_TIMEOUT) + 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(STALL_TIMEOUT - 1);

  logic [CNT_W-1:0] r_stall_cycles;
  logic [WD_W-1:0]  r_wd_cnt;
  logic             r_stall_timeout;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cycles  <= '0;
      r_wd_cnt        <= '0;
      r_stall_timeout <= 1'b0;
    end else begin
      if (i_stall_any && (r_stall_cycles != '1))
        r_stall_cycles <= r_stall_cycles + CNT_W'(1);
      // wd_cnt parks at its terminal value so a long stall cannot wrap it
      if (i_stall_pc) begin
        if (r_wd_cnt != WD_LAST)
          r_wd_cnt <= r_wd_cnt + WD_W'(1);
        if (r_wd_cnt == WD_LAST)
          r_stall_timeout <= 1'b1;
      end else begin
        r_wd_cnt <= '0;
      end
    end
  end

  assign o_stall_cycles  = rst ? '0 : r_stall_cycles;
  assign o_stall_timeout = rst ? 1'b0 : r_stall_timeout;

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - merges stage stall requests, turns MEM exceptions into flush+redirect,
// deferring the redirect while an instruction fetch is still outstanding.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR    = 32'h0000_0020,
  parameter int          STALL_TIMEOUT = 1024,
  parameter int          CNT_W         = 32
) (
  input  logic     clk,
  input  logic     rst,
  pipe_ctrl_if.slave bus
);

  state_e      r_state;
  state_e      w_state_nxt;
  logic [31:0] r_pend_pc;
  logic        w_pend_load;
  logic        w_exc;
  logic [31:0] w_vector;
  logic [5:0]  w_stall_dec;
  logic [5:0]  w_stall;
  logic        w_flush;
  logic        w_pc_redirect;
  logic [31:0] w_new_pc;
  logic [CNT_W-1:0] w_stall_cycles;
  logic             w_stall_timeout;

  assign w_exc    = (bus.excepttype_i != EXC_NONE);
  assign w_vector = exc_target(bus.excepttype_i, bus.cp0_epc_i, EXC_VECTOR);

  always_comb begin
    w_stall_dec = STALL_NONE;
    if (bus.stallreq_from_mem)     w_stall_dec = STALL_MEM;
    else if (bus.stallreq_from_ex) w_stall_dec = STALL_EX;
    else if (bus.stallreq_from_id) w_stall_dec = STALL_ID;
    else if (bus.stallreq_from_if) w_stall_dec = STALL_IF;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_RUN;
      r_pend_pc <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_pend_load)
        r_pend_pc <= w_vector;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pend_load = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (w_exc && bus.stallreq_from_if) begin
          w_state_nxt = ST_WAIT_IF;
          w_pend_load = 1'b1;
        end
      end
      ST_WAIT_IF: begin
        if (!bus.stallreq_from_if)
          w_state_nxt = ST_RUN;
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  // In WAIT_IF the pipeline is already empty, so only the fetch request matters.
  always_comb begin
    w_stall       = STALL_NONE;
    w_flush       = 1'b0;
    w_pc_redirect = 1'b0;
    w_new_pc      = '0;
    if (!rst) begin
      case (r_state)
        ST_RUN: begin
          if (w_exc) begin
            w_flush = FLUSH;
            if (!bus.stallreq_from_if) begin
              w_pc_redirect = 1'b1;
              w_new_pc      = w_vector;
            end
          end else begin
            w_stall = w_stall_dec;
          end
        end
        ST_WAIT_IF: begin
          if (bus.stallreq_from_if) begin
            w_stall = STALL_IF;
          end else begin
            w_flush       = FLUSH;
            w_pc_redirect = 1'b1;
            w_new_pc      = r_pend_pc;
          end
        end
        default: ;
      endcase
    end
  end

  pipe_stall_mon #(
    .STALL_TIMEOUT (STALL_TIMEOUT),
    .CNT_W         (CNT_W)
  ) u_stall_mon (
    .clk             (clk),
    .rst             (rst),
    .i_stall_pc      (w_stall[0]),
    .i_stall_any     (w_stall != STALL_NONE),
    .o_stall_cycles  (w_stall_cycles),
    .o_stall_timeout (w_stall_timeout)
  );

  assign bus.stall         = w_stall;
  assign bus.flush         = w_flush;
  assign bus.pc_redirect   = w_pc_redirect;
  assign bus.new_pc        = w_new_pc;
  assign bus.stall_cycles  = w_stall_cycles;
  assign bus.stall_timeout = w_stall_timeout;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - directed vector bench for pipe_ctrl with STALL_TIMEOUT=8
module tb_pipe_ctrl;

  localparam int CNT_W = 32;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  pipe_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pipe_ctrl #(
    .EXC_VECTOR    (32'h0000_0020),
    .STALL_TIMEOUT (8),
    .CNT_W         (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string       name;
    logic        mem, ex, id, ifr;
    logic [31:0] exc, epc;
    logic [5:0]  e_stall;
    logic        e_flush, e_redir;
    logic [31:0] e_pc;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic mem, input logic ex, input logic id, input logic ifr,
                        input logic [31:0] exc, input logic [31:0] epc);
    bus.stallreq_from_mem = mem;
    bus.stallreq_from_ex  = ex;
    bus.stallreq_from_id  = id;
    bus.stallreq_from_if  = ifr;
    bus.excepttype_i      = exc;
    bus.cp0_epc_i         = epc;
  endtask

  task automatic chk_out(input string name, input logic [5:0] e_stall, input logic e_flush,
                         input logic e_redir, input logic [31:0] e_pc);
    chk({name, ".stall"}, 64'(bus.stall), 64'(e_stall));
    chk({name, ".flush"}, 64'(bus.flush), 64'(e_flush));
    chk({name, ".redir"}, 64'(bus.pc_redirect), 64'(e_redir));
    chk({name, ".new_pc"}, 64'(bus.new_pc), 64'(e_pc));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_in(0, 0, 0, 0, 32'h0, 32'h0);
    tick();
    rst = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{"idle",      0,0,0,0, 32'h0, 32'h0,      6'b000000, 0,0, 32'h0};
    vecs[1]  = '{"if_only",   0,0,0,1, 32'h0, 32'h0,      6'b000111, 0,0, 32'h0};
    vecs[2]  = '{"id_only",   0,0,1,0, 32'h0, 32'h0,      6'b000111, 0,0, 32'h0};
    vecs[3]  = '{"id_ex",     0,1,1,0, 32'h0, 32'h0,      6'b001111, 0,0, 32'h0};
    vecs[4]  = '{"id_drop_ex",0,0,1,0, 32'h0, 32'h0,      6'b000111, 0,0, 32'h0};
    vecs[5]  = '{"all_req",   1,1,1,1, 32'h0, 32'h0,      6'b011111, 0,0, 32'h0};
    vecs[6]  = '{"ex_only",   0,1,0,0, 32'h0, 32'h0,      6'b001111, 0,0, 32'h0};
    vecs[7]  = '{"syscall",   0,0,0,0, 32'h8, 32'h0,      6'b000000, 1,1, 32'h20};
    vecs[8]  = '{"eret",      0,0,0,0, 32'he, 32'h1234,   6'b000000, 1,1, 32'h1234};
    vecs[9]  = '{"ov_vs_stall",1,1,0,0,32'hc, 32'h0,      6'b000000, 1,1, 32'h20};
    vecs[10] = '{"ri",        0,0,0,0, 32'ha, 32'h9999,   6'b000000, 1,1, 32'h20};
    vecs[11] = '{"trap",      0,0,1,0, 32'hd, 32'h0,      6'b000000, 1,1, 32'h20};
    vecs[12] = '{"int_vs_id", 0,0,1,0, 32'h1, 32'h5555,   6'b000000, 1,1, 32'h20};

    // outputs forced low while rst is high, even with requests present
    rst = 1'b1;
    set_in(1, 1, 0, 0, 32'he, 32'h1234);
    @(negedge clk);
    chk_out("in_reset", 6'b0, 1'b0, 1'b0, 32'h0);
    chk("in_reset.cycles", 64'(bus.stall_cycles), 64'h0);
    chk("in_reset.timeout", 64'(bus.stall_timeout), 64'h0);
    tick();
    rst = 1'b0;
    set_in(0, 0, 0, 0, 32'h0, 32'h0);
    @(negedge clk);
    chk_out("post_reset", 6'b0, 1'b0, 1'b0, 32'h0);
    chk("post_reset.cycles", 64'(bus.stall_cycles), 64'h0);
    tick();

    for (int i = 0; i < 13; i++) begin
      set_in(vecs[i].mem, vecs[i].ex, vecs[i].id, vecs[i].ifr, vecs[i].exc, vecs[i].epc);
      @(negedge clk);
      chk_out(vecs[i].name, vecs[i].e_stall, vecs[i].e_flush, vecs[i].e_redir, vecs[i].e_pc);
      tick();
    end
    // rows 1..6 each stalled once
    set_in(0, 0, 0, 0, 32'h0, 32'h0);
    @(negedge clk);
    chk("table.cycles", 64'(bus.stall_cycles), 64'd6);
    tick();

    // deferred redirect, with mem request and a new exception ignored in WAIT_IF
    set_in(0, 0, 0, 1, 32'h1, 32'h0);
    @(negedge clk);
    chk_out("defer.c0", 6'b0, 1'b1, 1'b0, 32'h0);
    tick();
    set_in(0, 0, 0, 1, 32'h0, 32'h0);
    @(negedge clk);
    chk_out("defer.c1", 6'b000111, 1'b0, 1'b0, 32'h0);
    tick();
    set_in(1, 0, 0, 1, 32'hc, 32'h7777);
    @(negedge clk);
    chk_out("defer.c2_ignored", 6'b000111, 1'b0, 1'b0, 32'h0);
    tick();
    set_in(0, 0, 0, 1, 32'h0, 32'h0);
    @(negedge clk);
    chk_out("defer.c3", 6'b000111, 1'b0, 1'b0, 32'h0);
    tick();
    set_in(0, 0, 0, 0, 32'h0, 32'h0);
    @(negedge clk);
    chk_out("defer.c4", 6'b0, 1'b1, 1'b1, 32'h20);
    tick();
    set_in(0, 0, 1, 0, 32'h0, 32'h0);
    @(negedge clk);
    chk_out("defer.back_run", 6'b000111, 1'b0, 1'b0, 32'h0);
    tick();

    // ERET deferred then reset mid-WAIT_IF: no redirect afterwards
    set_in(0, 0, 0, 1, 32'he, 32'h4444);
    @(negedge clk);
    chk_out("rstwait.enter", 6'b0, 1'b1, 1'b0, 32'h0);
    tick();
    do_reset();
    @(negedge clk);
    chk_out("rstwait.after", 6'b0, 1'b0, 1'b0, 32'h0);
    tick();

    // watchdog and counter
    do_reset();
    for (int c = 0; c < 8; c++) begin
      set_in(0, 1, 0, 0, 32'h0, 32'h0);
      @(negedge clk);
      chk($sformatf("wd.stall%0d", c), 64'(bus.stall), 64'(6'b001111));
      chk($sformatf("wd.flag%0d", c), 64'(bus.stall_timeout), 64'h0);
      tick();
    end
    set_in(0, 0, 0, 0, 32'h0, 32'h0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("wd.sticky%0d", c), 64'(bus.stall_timeout), 64'h1);
      chk($sformatf("wd.cycles%0d", c), 64'(bus.stall_cycles), 64'd8);
      tick();
    end
    do_reset();
    @(negedge clk);
    chk("wd.cleared", 64'(bus.stall_timeout), 64'h0);
    chk("wd.cycles_cleared", 64'(bus.stall_cycles), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
